// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared 640x480 VGA timing defaults, derived raster bounds and
//                a sync-level helper. Imported by the scan driver and by the
//                colour memory so both agree on the visible area.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Timing defaults (pixels / lines)
    localparam int unsigned VGA_CLK_DIV  = 4;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam bit          VGA_SYNC_POL = 1'b0;

    // Derived raster constants for the default timing
    localparam int unsigned H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int unsigned H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int unsigned V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;

    // Line address presented while the raster is outside the visible lines
    localparam logic [8:0]  ADDRV_OFFSCREEN = 9'd511;

    // Pin level for a sync signal given whether it is asserted and its polarity
    function automatic logic sync_level(input logic asserted, input bit pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/pixel_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_tick_gen
//  Description : Divides clk down to the pixel rate. tick is high on the last
//                clk of every CLK_DIV-cycle pixel period; constant 1 when
//                CLK_DIV is 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    generate
        if (CLK_DIV <= 1) begin : g_div1
            // Every clk is a pixel; the clock and reset are not needed here
            logic unused_div1;
            assign unused_div1 = clk ^ rst_n;
            assign tick        = 1'b1;
        end else begin : g_divn
            localparam int unsigned C_CW = $clog2(CLK_DIV);
            localparam logic [C_CW-1:0] C_LAST = C_CW'(CLK_DIV - 1);

            logic [C_CW-1:0] pix_cnt_q;
            logic [C_CW-1:0] pix_cnt_d;

            // Next divider value: wrap to zero after the last clk of the pixel
            always_comb begin
                pix_cnt_d = (pix_cnt_q == C_LAST) ? '0 : pix_cnt_q + C_CW'(1);
            end

            // Divider register, cleared by synchronous reset
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    pix_cnt_q <= '0;
                end else begin
                    pix_cnt_q <= pix_cnt_d;
                end
            end

            assign tick = (pix_cnt_q == C_LAST);
        end
    endgenerate

endmodule : pixel_tick_gen
`default_nettype wire

// File: rtl/vga_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scan_driver
//  Description : Free-running VGA raster generator. Presents the scan address
//                to the colour memory, samples the returned colour once per
//                pixel and registers RGB/HS/VS/ACTIVE/FRAME_START together so
//                all pins stay mutually aligned.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_driver
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter bit          SYNC_POL = VGA_SYNC_POL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] COLOUR_IN,
    output logic [9:0]  ADDRH,
    output logic [8:0]  ADDRV,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        ACTIVE,
    output logic        FRAME_START
);

    // Raster bounds derived from the timing parameters, sized to the counters
    localparam logic [9:0] C_H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] C_V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] C_H_ACTIVE   = 10'(H_ACTIVE);
    localparam logic [9:0] C_V_ACTIVE   = 10'(V_ACTIVE);
    localparam logic [9:0] C_HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] C_HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] C_VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] C_VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic        tick;

    logic [9:0]  hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;

    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        active_q, active_d;
    logic        frame_start_q, frame_start_d;

    logic        visible;
    logic        visible_line;
    logic        hs_on;
    logic        vs_on;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Decode of the current raster position
    assign visible_line = (vcnt_q < C_V_ACTIVE);
    assign visible      = (hcnt_q < C_H_ACTIVE) && visible_line;
    assign hs_on        = (hcnt_q >= C_HS_FIRST) && (hcnt_q <= C_HS_LAST);
    assign vs_on        = (vcnt_q >= C_VS_FIRST) && (vcnt_q <= C_VS_LAST);

    // Scan address to the colour memory, stable for the whole pixel period
    assign ADDRH = hcnt_q;
    assign ADDRV = visible_line ? vcnt_q[8:0] : ADDRV_OFFSCREEN;

    // Raster counters: advance one pixel per tick, line wrap bumps the line
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (tick) begin
            if (hcnt_q == C_H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == C_V_LAST) ? '0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end
    end

    // Output register inputs: load the sampled pixel on tick, pulse FRAME_START for one clk
    always_comb begin
        rgb_d         = rgb_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        active_d      = active_q;
        frame_start_d = 1'b0;
        if (tick) begin
            rgb_d         = visible ? COLOUR_IN : 12'h000;
            hs_d          = sync_level(hs_on, SYNC_POL);
            vs_d          = sync_level(vs_on, SYNC_POL);
            active_d      = visible;
            frame_start_d = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
        end
    end

    // State registers; reset restarts the raster at (0,0) with syncs deasserted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            rgb_q         <= '0;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign VGA_R       = rgb_q[11:8];
    assign VGA_G       = rgb_q[7:4];
    assign VGA_B       = rgb_q[3:0];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign ACTIVE      = active_q;
    assign FRAME_START = frame_start_q;

endmodule : vga_scan_driver
`default_nettype wire

// File: tb/tb_vga_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_scan_driver
//  Description : Self-checking bench for vga_scan_driver on a shrunken raster.
//                Expected pins and addresses are derived from the clock count
//                since reset release with plain division/modulo arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_driver;

    localparam int D   = 4;
    localparam int HA  = 20;
    localparam int HF  = 4;
    localparam int HSY = 6;
    localparam int HB  = 5;
    localparam int VA  = 12;
    localparam int VF  = 2;
    localparam int VSY = 2;
    localparam int VB  = 3;
    localparam int HT  = HA + HF + HSY + HB;
    localparam int VT  = VA + VF + VSY + VB;

    logic        clk;
    logic        rst_n;
    logic [11:0] colour_in;
    logic [9:0]  addrh;
    logic [8:0]  addrv;
    logic        vga_hs;
    logic        vga_vs;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        active;
    logic        frame_start;

    vga_scan_driver #(
        .CLK_DIV  (D),
        .H_ACTIVE (HA),
        .H_FP     (HF),
        .H_SYNC   (HSY),
        .H_BP     (HB),
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (VSY),
        .V_BP     (VB),
        .SYNC_POL (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .COLOUR_IN   (colour_in),
        .ADDRH       (addrh),
        .ADDRV       (addrv),
        .VGA_HS      (vga_hs),
        .VGA_VS      (vga_vs),
        .VGA_R       (vga_r),
        .VGA_G       (vga_g),
        .VGA_B       (vga_b),
        .ACTIVE      (active),
        .FRAME_START (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: k = clk edges since reset release (0 while in reset)
    int          k = 0;
    logic [11:0] exp_rgb;
    logic        exp_hs, exp_vs, exp_act, exp_fs;
    int          exp_ah, exp_av;

    // Interval trackers on the output pins
    int cyc          = 0;
    bit prev_hs      = 1'b1;
    bit prev_vs      = 1'b1;
    int last_hs_fall = -1;
    int hs_low_start = -1;
    int vs_low_start = -1;
    int last_fs      = -1;
    bit want_ofs     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Advance the model by one clk edge with the inputs present at that edge
    task automatic model_edge(input bit r, input logic [11:0] c);
        int p, h, v, a;
        if (!r) begin
            k       = 0;
            exp_rgb = 12'h000;
            exp_hs  = 1'b1;
            exp_vs  = 1'b1;
            exp_act = 1'b0;
            exp_fs  = 1'b0;
        end else begin
            k++;
            exp_fs = 1'b0;
            if (k % D == 0) begin
                p       = k / D - 1;
                h       = p % HT;
                v       = (p / HT) % VT;
                exp_act = (h < HA) && (v < VA);
                exp_rgb = exp_act ? c : 12'h000;
                exp_hs  = !((h >= HA + HF) && (h < HA + HF + HSY));
                exp_vs  = !((v >= VA + VF) && (v < VA + VF + VSY));
                exp_fs  = (h == 0) && (v == 0);
            end
        end
        a      = k / D;
        exp_ah = a % HT;
        v      = (a / HT) % VT;
        exp_av = (v < VA) ? v : 511;
    endtask

    // One clk: drive inputs, model the edge, then check pins on the falling edge
    task automatic step(input bit r, input logic [11:0] c);
        rst_n     = r;
        colour_in = c;
        @(posedge clk);
        model_edge(r, c);
        @(negedge clk);
        cyc++;
        check("rgb",   {vga_r, vga_g, vga_b}, exp_rgb);
        check("hs",    vga_hs,      exp_hs);
        check("vs",    vga_vs,      exp_vs);
        check("act",   active,      exp_act);
        check("fs",    frame_start, exp_fs);
        check("addrh", addrh,       exp_ah);
        check("addrv", addrv,       exp_av);
        if (k == 0) begin
            last_hs_fall = -1;
            hs_low_start = -1;
            vs_low_start = -1;
            last_fs      = -1;
            want_ofs     = 1'b0;
        end else begin
            if (frame_start) begin
                if (last_fs >= 0) check("fs_period", cyc - last_fs, HT * VT * D);
                last_fs  = cyc;
                want_ofs = 1'b1;
            end
            if (prev_hs && !vga_hs) begin
                if (last_hs_fall >= 0) check("hs_period", cyc - last_hs_fall, HT * D);
                if (want_ofs) begin
                    check("hs_fall_ofs", cyc - last_fs, (HA + HF) * D);
                    want_ofs = 1'b0;
                end
                last_hs_fall = cyc;
                hs_low_start = cyc;
            end
            if (!prev_hs && vga_hs && hs_low_start >= 0)
                check("hs_low", cyc - hs_low_start, HSY * D);
            if (prev_vs && !vga_vs) vs_low_start = cyc;
            if (!prev_vs && vga_vs && vs_low_start >= 0)
                check("vs_low", cyc - vs_low_start, VSY * HT * D);
        end
        prev_hs = vga_hs;
        prev_vs = vga_vs;
    endtask

    function automatic logic [11:0] rnd_colour();
        return 12'($urandom_range(0, 4095));
    endfunction

    initial begin
        int guard;
        rst_n     = 1'b0;
        colour_in = 12'h000;
        @(negedge clk);

        // Reset held for 10 clocks
        repeat (10) step(1'b0, 12'h000);
        check("rst_hs",    vga_hs, 1);
        check("rst_vs",    vga_vs, 1);
        check("rst_rgb",   {vga_r, vga_g, vga_b}, 0);
        check("rst_addrh", addrh,  0);
        check("rst_addrv", addrv,  0);
        check("rst_act",   active, 0);

        // First pixel after release
        for (int i = 0; i < D; i++) step(1'b1, 12'hABC);
        check("first_rgb", {vga_r, vga_g, vga_b}, 12'hABC);
        check("first_act", active,      1);
        check("first_fs",  frame_start, 1);
        step(1'b1, rnd_colour());
        check("fs_width",  frame_start, 0);
        check("act_hold",  active,      1);

        // One frame of random colours
        repeat (HT * VT * D) step(1'b1, rnd_colour());

        // One frame of constant white to exercise blanking
        repeat (HT * VT * D + 200) step(1'b1, 12'hFFF);

        // Seek to line 9 inside the horizontal sync, then pulse reset
        guard = 0;
        while (!((((k / D) / HT) % VT == 9) && ((k / D) % HT == HA + HF + 3))
               && guard < HT * VT * D + 10) begin
            step(1'b1, rnd_colour());
            guard++;
        end
        check("seek_bound", (guard < HT * VT * D + 10), 1);
        check("pre_rst_hs", vga_hs, 0);
        step(1'b0, rnd_colour());
        check("mid_rst_hs",    vga_hs, 1);
        check("mid_rst_vs",    vga_vs, 1);
        check("mid_rst_addrh", addrh,  0);
        check("mid_rst_addrv", addrv,  0);
        for (int i = 0; i < D; i++) step(1'b1, rnd_colour());
        check("fs_after_rst", frame_start, 1);

        // Another full frame after the restart
        repeat (HT * VT * D + 300) step(1'b1, rnd_colour());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_vga_scan_driver
`default_nettype wire
